// File: rtl/word_unpacker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_unpacker_if
// Word-in / byte-out bus for word_unpacker.
//   master : the unpacker (drives word_req and the byte stream)
//   slave  : upstream FIFO + downstream sink (drive word_valid/word_data
//            and byte_ready)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface word_unpacker_if;
  logic        word_req;
  logic        word_valid;
  logic [31:0] word_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;

  modport master (
    output word_req, byte_valid, byte_data, byte_last,
    input  word_valid, word_data, byte_ready
  );

  modport slave (
    input  word_req, byte_valid, byte_data, byte_last,
    output word_valid, word_data, byte_ready
  );
endinterface
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_unpacker
// Splits 32-bit words from an upstream FIFO into a byte stream.
// Two-entry word buffer, 2-bit byte index on the head entry, sticky
// overflow flag and a wrapping count of fully emitted words.
// Ports:
//   clock, reset  : single clock, synchronous active-high reset
//   enable        : allow new word requests
//   bus (master)  : word_req/word_valid/word_data, byte_valid/byte_ready/
//                   byte_data/byte_last
//   word_count    : words fully emitted (wraps)
//   overflow      : sticky, a word arrived with no free slot
// Revision: 1.0
// ---------------------------------------------------------------------------
module word_unpacker #(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             enable,
  word_unpacker_if.master       bus,
  output logic [CNT_W-1:0]      word_count,
  output logic                  overflow
);

  localparam logic c_MSB = (MSB_FIRST != 0);

  logic [1:0]       r_count;
  logic [1:0]       r_idx;
  logic             r_req_q;
  logic [31:0]      r_head;
  logic [31:0]      r_tail;
  logic [CNT_W-1:0] r_word_count;
  logic             r_overflow;

  logic [2:0] w_occ;
  logic       w_req;
  logic       w_valid;
  logic       w_accept;
  logic       w_pop;
  logic [1:0] w_sel;
  logic [7:0] w_byte;

  // A request in flight is answered next cycle, so it already owns a slot.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_req_q};
  assign w_req    = enable & ~reset & (w_occ <= 3'd1);

  // Gated with reset so the outputs are quiet during the reset cycle itself.
  assign w_valid  = (r_count != 2'd0) & ~reset;
  assign w_accept = w_valid & bus.byte_ready;
  assign w_pop    = w_accept & (r_idx == 2'd3);

  // For a 2-bit index, 3-idx is the bitwise inverse.
  assign w_sel    = c_MSB ? ~r_idx : r_idx;
  assign w_byte   = r_head[{w_sel, 3'b000} +: 8];

  assign bus.word_req   = w_req;
  assign bus.byte_valid = w_valid;
  assign bus.byte_data  = w_valid ? w_byte : 8'h00;
  assign bus.byte_last  = w_valid & (r_idx == 2'd3);
  assign word_count     = r_word_count;
  assign overflow       = r_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_idx        <= 2'd0;
      r_req_q      <= 1'b0;
      r_head       <= 32'h0;
      r_tail       <= 32'h0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_req_q <= w_req;

      // Index wraps 3 -> 0 naturally on the popping byte.
      if (w_accept) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_pop) begin
        r_word_count <= r_word_count + 1'b1;
      end

      if (bus.word_valid) begin
        if (w_pop) begin
          // Pop and write together: occupancy unchanged, never overflows.
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= bus.word_data;
          end else begin
            r_head <= bus.word_data;
          end
        end else begin
          case (r_count)
            2'd0: begin
              r_head  <= bus.word_data;
              r_count <= 2'd1;
            end
            2'd1: begin
              r_tail  <= bus.word_data;
              r_count <= 2'd2;
            end
            default: r_overflow <= 1'b1;
          endcase
        end
      end else if (w_pop) begin
        r_head  <= r_tail;
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_word_unpacker
// Two word_unpacker instances (LSB-first and MSB-first) share one stimulus
// stream. The expected byte stream is a queue of (word, byte index)
// entries; the buffer occupancy is derived from that queue's length.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_word_unpacker;
  localparam int CNT_W = 4;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  always #5 clock = ~clock;

  word_unpacker_if ifc0 ();
  word_unpacker_if ifc1 ();

  logic [CNT_W-1:0] wc0, wc1;
  logic             ovf0, ovf1;

  assign ifc1.word_valid = ifc0.word_valid;
  assign ifc1.word_data  = ifc0.word_data;
  assign ifc1.byte_ready = ifc0.byte_ready;

  word_unpacker #(.MSB_FIRST(0), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .bus(ifc0),
    .word_count(wc0), .overflow(ovf0));

  word_unpacker #(.MSB_FIRST(1), .CNT_W(CNT_W)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .bus(ifc1),
    .word_count(wc1), .overflow(ovf1));

  typedef struct packed {
    logic [31:0] w;
    logic [1:0]  idx;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] src[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_wc = 0;
  bit          exp_ovf = 0;
  bit          prev_req = 0;
  bit          req_lat = 0;
  bit          force_v = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares both DUTs against the head of the scoreboard.
  always @(negedge clock) begin
    int   held;
    bit   exp_req;
    int   k;
    ent_t e;
    held = (sb.size() + 3) / 4;
    if (reset) begin
      exp_req = 1'b0;
      chk("rst_req", {31'b0, ifc0.word_req}, 0);
      chk("rst_valid0", {31'b0, ifc0.byte_valid}, 0);
      chk("rst_valid1", {31'b0, ifc1.byte_valid}, 0);
      chk("rst_data0", {24'b0, ifc0.byte_data}, 0);
      chk("rst_last0", {31'b0, ifc0.byte_last}, 0);
      sb.delete();
      exp_wc  = 0;
      exp_ovf = 0;
    end else begin
      exp_req = enable && (held + int'(prev_req) <= 1);
      chk("word_req0", {31'b0, ifc0.word_req}, {31'b0, exp_req});
      chk("word_req1", {31'b0, ifc1.word_req}, {31'b0, exp_req});
      chk("byte_valid0", {31'b0, ifc0.byte_valid}, {31'b0, sb.size() != 0});
      chk("byte_valid1", {31'b0, ifc1.byte_valid}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        e = sb[0];
        k = int'(e.idx);
        chk("byte_data_lsb", {24'b0, ifc0.byte_data}, (e.w >> (8 * k)) & 32'hFF);
        chk("byte_data_msb", {24'b0, ifc1.byte_data}, (e.w >> (8 * (3 - k))) & 32'hFF);
        chk("byte_last0", {31'b0, ifc0.byte_last}, {31'b0, k == 3});
        chk("byte_last1", {31'b0, ifc1.byte_last}, {31'b0, k == 3});
      end else begin
        chk("idle_data0", {24'b0, ifc0.byte_data}, 0);
        chk("idle_data1", {24'b0, ifc1.byte_data}, 0);
      end
      chk("word_count0", {28'b0, wc0}, exp_wc % (1 << CNT_W));
      chk("word_count1", {28'b0, wc1}, exp_wc % (1 << CNT_W));
      chk("overflow0", {31'b0, ovf0}, {31'b0, exp_ovf});
      chk("overflow1", {31'b0, ovf1}, {31'b0, exp_ovf});
      if (sb.size() != 0 && ifc0.byte_ready) begin
        if (sb[0].idx == 2'd3) exp_wc++;
        void'(sb.pop_front());
      end
    end
    prev_req = exp_req;
  end

  // Scoreboard push: runs after the monitor has retired this cycle's byte,
  // so the queue already reflects any pop happening at the coming edge.
  always @(negedge clock) begin
    #1;
    if (!reset && ifc0.word_valid === 1'b1) begin
      if ((sb.size() + 3) / 4 < 2) begin
        for (int i = 0; i < 4; i++) sb.push_back('{ifc0.word_data, 2'(i)});
      end else begin
        exp_ovf = 1'b1;
      end
    end
  end

  // Upstream FIFO answers a request one cycle later.
  always @(negedge clock) req_lat = ifc0.word_req;

  task automatic step(input bit rst, input bit en, input bit rdy, input bit fv);
    @(posedge clock);
    #1;
    reset           = rst;
    enable          = en;
    ifc0.byte_ready = rdy;
    if (req_lat || fv) begin
      ifc0.word_valid = 1'b1;
      ifc0.word_data  = (src.size() != 0) ? src.pop_front() : $urandom;
    end else begin
      ifc0.word_valid = 1'b0;
      ifc0.word_data  = $urandom;
    end
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    ifc0.byte_ready = 1'b0;
    ifc0.word_valid = 1'b0;
    ifc0.word_data  = 32'h0;
    repeat (3) step(1, 0, 0, 0);

    // Single word, LSB-first and MSB-first orders.
    src.push_back(32'h44332211);
    step(0, 1, 1, 0);
    repeat (8) step(0, 0, 1, 0);

    // Streaming 16 words 0x03020100 .. 0x3F3E3D3C.
    for (int i = 0; i < 16; i++)
      src.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    for (int k = 0; k < 100 && src.size() != 0; k++) step(0, 1, 1, 0);
    repeat (12) step(0, 0, 1, 0);

    // Backpressure with the buffer full, then drain.
    repeat (8) step(0, 1, 0, 0);
    repeat (12) step(0, 0, 1, 0);

    // Error injection: three forced words with no drain.
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    repeat (12) step(0, 0, 1, 0);

    // Reset after two bytes of a word.
    src.push_back(32'h44332211);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);

    // Random traffic, including word_valid coinciding with reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 10) < 6,
           ($urandom % 40) == 0);
    repeat (12) step(0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
